// File: rtl/jt12_slot_pkg.sv
// Shared constants, FSM state type and head-slot arithmetic for jt12 slot
// serializers and the sep24-style monitors that decode their streams.
package jt12_slot_pkg;

  localparam int SLOTS = 24;
  localparam int CNTW  = 5;

  typedef enum logic {
    IDLE,
    PEND
  } slot_fsm_e;

  // Slot index currently on the head for a given counter value. The sum is
  // formed in 6 bits so cnt+24-pos0 can never underflow before the reduction.
  function automatic logic [CNTW-1:0] head_slot(input logic [CNTW-1:0] cnt,
                                                input int unsigned     pos0);
    logic [5:0] t;
    t = {1'b0, cnt} + 6'd24 - 6'(pos0);
    return CNTW'(t % 6'd24);
  endfunction

endpackage

// File: rtl/jt12_slot_mux_if.sv
// Host-side write (and optional readback) handshake for jt12_slot_mux.
// Readback signals exist only when JT12_SLOT_RDBK_EN is defined.
interface jt12_slot_mux_if
  import jt12_slot_pkg::*;
#(
  parameter int width = 10
);

  logic              wr_req;
  logic [CNTW-1:0]   wr_slot;
  logic [width-1:0]  wr_data;
  logic              wr_busy;
  logic              wr_done;
  logic              wr_err;

`ifdef JT12_SLOT_RDBK_EN
  logic              rd_req;
  logic [CNTW-1:0]   rd_slot;
  logic [width-1:0]  rd_data;
  logic              rd_valid;

  modport master (
    output wr_req, wr_slot, wr_data, rd_req, rd_slot,
    input  wr_busy, wr_done, wr_err, rd_data, rd_valid
  );

  modport slave (
    input  wr_req, wr_slot, wr_data, rd_req, rd_slot,
    output wr_busy, wr_done, wr_err, rd_data, rd_valid
  );
`else
  modport master (
    output wr_req, wr_slot, wr_data,
    input  wr_busy, wr_done, wr_err
  );

  modport slave (
    input  wr_req, wr_slot, wr_data,
    output wr_busy, wr_done, wr_err
  );
`endif

endinterface

// File: rtl/jt12_slot_ring.sv
// 24-entry circular shift register: the head entry is presented on 'head'
// and recirculates to the tail on each enable unless the tail is overridden.
module jt12_slot_ring
  import jt12_slot_pkg::*;
#(
  parameter int               width = 10,
  parameter logic [width-1:0] init  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ovr,
  input  logic [width-1:0] ovr_data,
  output logic [width-1:0] head
);

  logic [width-1:0] ring [SLOTS];

  // NOTE: every entry is reset because the slots must hold init after reset;
  // a storage array is normally left unreset so it can map onto RAM, but a
  // shift register of flops has no such constraint.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) ring[i] <= init;
    end else if (en) begin
      for (int i = 0; i < SLOTS - 1; i++) ring[i] <= ring[i+1];
      ring[SLOTS-1] <= ovr ? ovr_data : ring[0];
    end
  end

  assign head = ring[0];

endmodule

// File: rtl/jt12_slot_mux.sv
// Serializes 24 per-slot values onto 'mixed' in step with a 0..23 counter;
// host writes are held until their slot reaches the head, then inserted.
// Optional readback port: define JT12_SLOT_RDBK_EN.
module jt12_slot_mux
  import jt12_slot_pkg::*;
#(
  parameter int               width = 10,
  parameter int               pos0  = 0,
  parameter logic [width-1:0] init  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  jt12_slot_mux_if.slave    bus,
  output logic [CNTW-1:0]   cnt,
  output logic              zero,
  output logic [width-1:0]  mixed
);

  logic [CNTW-1:0]  head;
  slot_fsm_e        wr_state, wr_next;
  logic [CNTW-1:0]  wr_slot_q;
  logic [width-1:0] wr_data_q;
  logic             wr_err_q, wr_err_d;
  logic             wr_accept, wr_ins;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clk_en) cnt <= (cnt == CNTW'(SLOTS - 1)) ? '0 : cnt + CNTW'(1);
  end

  assign zero = (cnt == '0);
  assign head = head_slot(cnt, pos0);

  // NOTE: every output of this block is given a default first so that no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    wr_next   = wr_state;
    wr_accept = 1'b0;
    wr_ins    = 1'b0;
    wr_err_d  = 1'b0;
    case (wr_state)
      IDLE: begin
        if (bus.wr_req) begin
          if (bus.wr_slot < CNTW'(SLOTS)) begin
            wr_accept = 1'b1;
            wr_next   = PEND;
          end else begin
            wr_err_d  = 1'b1;
          end
        end
      end
      PEND: begin
        // Replace the head value on its way to the tail.
        if (clk_en && !rst && head == wr_slot_q) begin
          wr_ins  = 1'b1;
          wr_next = IDLE;
        end
      end
      default: wr_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= IDLE;
      wr_err_q  <= 1'b0;
      wr_slot_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_state <= wr_next;
      wr_err_q <= wr_err_d;
      if (wr_accept) begin
        wr_slot_q <= bus.wr_slot;
        wr_data_q <= bus.wr_data;
      end
    end
  end

  assign bus.wr_busy = (wr_state == PEND);
  assign bus.wr_done = wr_ins;
  assign bus.wr_err  = wr_err_q;

  jt12_slot_ring #(
    .width (width),
    .init  (init)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .ovr      (wr_ins),
    .ovr_data (wr_data_q),
    .head     (mixed)
  );

`ifdef JT12_SLOT_RDBK_EN
  slot_fsm_e        rd_state, rd_next;
  logic [CNTW-1:0]  rd_slot_q;
  logic [width-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             rd_accept, rd_hit;

  // Capturing the head before the tail override returns the old value when a
  // write lands on the same slot in the same cycle.
  always_comb begin
    rd_next   = rd_state;
    rd_accept = 1'b0;
    rd_hit    = 1'b0;
    case (rd_state)
      IDLE: begin
        if (bus.rd_req && bus.rd_slot < CNTW'(SLOTS)) begin
          rd_accept = 1'b1;
          rd_next   = PEND;
        end
      end
      PEND: begin
        if (clk_en && head == rd_slot_q) begin
          rd_hit  = 1'b1;
          rd_next = IDLE;
        end
      end
      default: rd_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= IDLE;
      rd_slot_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_state   <= rd_next;
      rd_valid_q <= rd_hit;
      if (rd_accept) rd_slot_q <= bus.rd_slot;
      if (rd_hit) rd_data_q <= mixed;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

endmodule
